// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares the single-ported data RAM between the CPU MEM stage
//                and an external requester (CPU priority, bounded EXT bursts)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            cpu_mem_op,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_stall,
  input  logic                  ext_req,
  input  logic                  ext_write,
  input  logic [ADDR_WIDTH-1:0] ext_address,
  input  logic [DATA_WIDTH-1:0] ext_write_data,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_read_data,
  output logic [1:0]            ram_mem_op,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

  typedef enum logic [0:0] {
    CPU_PRI = 1'b0,
    EXT_PRI = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic                    ext_rvalid_q, ext_rvalid_d;
  logic [DATA_WIDTH-1:0]   ext_read_data_q, ext_read_data_d;

  logic                    cpu_act;
  logic                    ext_win;
  logic                    cpu_win;
  logic [BURST_W-1:0]      burst_next;

  assign cpu_act = (cpu_mem_op == 2'b01) || (cpu_mem_op == 2'b10);

  // Grant decision; everything is forced idle while reset is held.
  always_comb begin
    ext_win = 1'b0;
    cpu_win = 1'b0;
    if (reset_n) begin
      if (ext_req && ((state_q == EXT_PRI) || !cpu_act || (wait_cnt_q == WAIT_LIMIT))) begin
        ext_win = 1'b1;
      end else if (cpu_act) begin
        cpu_win = 1'b1;
      end
    end
  end

  always_comb begin
    ram_mem_op     = 2'b00;
    ram_address    = cpu_address;
    ram_write_data = cpu_write_data;
    if (ext_win) begin
      ram_mem_op     = {ext_write, ~ext_write};
      ram_address    = ext_address;
      ram_write_data = ext_write_data;
    end else if (cpu_win) begin
      ram_mem_op     = cpu_mem_op;
    end
  end

  assign ext_gnt       = ext_win;
  assign cpu_stall     = ext_win && cpu_act;
  assign cpu_read_data = ram_read_data;
  assign ext_rvalid    = ext_rvalid_q;
  assign ext_read_data = ext_read_data_q;

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    burst_cnt_d     = burst_cnt_q;
    burst_next      = (state_q == EXT_PRI) ? (burst_cnt_q + BURST_W'(1)) : BURST_W'(1);
    ext_rvalid_d    = ext_win && !ext_write;
    ext_read_data_d = ext_rvalid_d ? ram_read_data : ext_read_data_q;

    if (ext_win) begin
      wait_cnt_d = '0;
      // The win that completes the burst hands priority straight back.
      if (burst_next == BURST_LIMIT) begin
        state_d     = CPU_PRI;
        burst_cnt_d = '0;
      end else begin
        state_d     = EXT_PRI;
        burst_cnt_d = burst_next;
      end
    end else begin
      if (!ext_req) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_LIMIT) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
      if (state_q == EXT_PRI) begin
        state_d     = CPU_PRI;
        burst_cnt_d = '0;
        wait_cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= CPU_PRI;
      wait_cnt_q      <= '0;
      burst_cnt_q     <= '0;
      ext_rvalid_q    <= 1'b0;
      ext_read_data_q <= '0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      burst_cnt_q     <= burst_cnt_d;
      ext_rvalid_q    <= ext_rvalid_d;
      ext_read_data_q <= ext_read_data_d;
    end
  end

endmodule

`default_nettype wire
